// File: rtl/div_if.sv
// Operand/result bundle between the execute stage (master) and the iterative divider (slave).
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Returns {remainder, quotient}; result held while start_i stays high.
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [64:0] work_r, work_s;
  logic [31:0] divisor_r, divisor_s;
  logic        neg_q_r, neg_q_s;
  logic        neg_r_r, neg_r_s;
  logic [63:0] result_r, result_s;
  logic        ready_r, ready_s;

  logic [33:0] upper_s;
  logic        geq_s;
  logic [64:0] step_s;

  // Two's complement magnitude of an operand when signed mode is active.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      magnitude = ~v + 32'd1;
    end else begin
      magnitude = v;
    end
  endfunction

  // Conditional two's complement negation.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    if (neg) begin
      neg_if = ~v + 32'd1;
    end else begin
      neg_if = v;
    end
  endfunction

  // One restoring step: shifted partial remainder (34 bits so the compare never wraps).
  assign upper_s = work_r[64:31];
  assign geq_s   = (upper_s >= {2'b00, divisor_r});
  assign step_s  = geq_s ? {33'(upper_s - {2'b00, divisor_r}), work_r[30:0], 1'b1}
                         : {upper_s[32:0], work_r[30:0], 1'b0};

  // Next-state and next-output logic for the divider FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    work_s    = work_r;
    divisor_s = divisor_r;
    neg_q_s   = neg_q_r;
    neg_r_s   = neg_r_r;
    result_s  = result_r;
    ready_s   = ready_r;

    case (state_r)
      ST_FREE: begin
        ready_s  = 1'b0;
        result_s = 64'd0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_s = ST_BYZERO;
          end else begin
            state_s   = ST_ON;
            cnt_s     = 6'd0;
            work_s    = {33'd0, magnitude(bus.opdata1_i, bus.signed_div_i)};
            divisor_s = magnitude(bus.opdata2_i, bus.signed_div_i);
            neg_q_s   = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_r_s   = bus.signed_div_i && bus.opdata1_i[31];
          end
        end else begin
          state_s = ST_FREE;
        end
      end
      ST_BYZERO: begin
        result_s = 64'd0;
        if (bus.annul_i) begin
          state_s = ST_FREE;
          ready_s = 1'b0;
        end else begin
          state_s = ST_END;
          ready_s = 1'b1;
        end
      end
      ST_ON: begin
        if (bus.annul_i) begin
          state_s  = ST_FREE;
          ready_s  = 1'b0;
          result_s = 64'd0;
        end else begin
          work_s = step_s;
          cnt_s  = cnt_r + 6'd1;
          // Last step: correct signs on the freshly computed quotient/remainder.
          if (cnt_r == 6'd31) begin
            state_s  = ST_END;
            ready_s  = 1'b1;
            result_s = {neg_if(step_s[63:32], neg_r_r), neg_if(step_s[31:0], neg_q_r)};
          end else begin
            state_s = ST_ON;
          end
        end
      end
      ST_END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_s  = ST_FREE;
          ready_s  = 1'b0;
          result_s = 64'd0;
        end else begin
          state_s = ST_END;
        end
      end
      default: begin
        state_s  = ST_FREE;
        ready_s  = 1'b0;
        result_s = 64'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FREE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered output state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 6'd0;
      work_r    <= 65'd0;
      divisor_r <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      result_r  <= 64'd0;
      ready_r   <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      work_r    <= work_s;
      divisor_r <= divisor_s;
      neg_q_r   <= neg_q_s;
      neg_r_r   <= neg_r_s;
      result_r  <= result_s;
      ready_r   <= ready_s;
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

endmodule

// File: doc/div.md
# div

Iterative 32-bit signed/unsigned integer divider serving the execute stage, downstream of instruction decode. EX issues `div`/`divu` operands (decoded source operands 1 and 2) with a start request. EX holds the pipeline while the divider runs. The divider returns a 64-bit {remainder, quotient} word for the HI/LO write path and signals completion with `ready_o`.

## Interface
Parameters:
- none. Datapath width is fixed at 32 bits, matching `RegBus`.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `signed_div_i` in 1: 1 = signed (`div`), 0 = unsigned (`divu`). Sampled with `start_i`.
- `opdata1_i` in 32: dividend. Sampled when a start is accepted.
- `opdata2_i` in 32: divisor. Sampled when a start is accepted.
- `start_i` in 1: divide request. Level held by EX until it has consumed the result.
- `annul_i` in 1: cancel request (exception/flush). Aborts any operation in progress.
- `result_o` out 64: {remainder[63:32], quotient[31:0]}. Nonzero only while `ready_o` = 1.
- `ready_o` out 1: result valid.

## Operation
- Four-state FSM:
  - FREE: idle. Reset state.
  - BYZERO: divisor-zero path.
  - ON: iterating.
  - END: result presented.
- FREE:
  - `start_i`=1 and `annul_i`=0, divisor 0 → BYZERO.
  - `start_i`=1 and `annul_i`=0, divisor nonzero → ON, with operands and sign mode captured. Iteration counter cnt is cleared to 0.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- Operand preparation (signed mode): a negative operand is replaced by its two's complement magnitude. Unsigned mode uses operands as-is.
- ON:
  - Restoring divide on a 65-bit working register {partial remainder[64:32], dividend/quotient[31:0]}, initialised to {33'b0, |dividend|}.
  - Per cycle: shift the register left 1, then subtract {1'b0, |divisor|} from the upper 33 bits.
  - Non-negative difference: the upper bits take the difference and the new LSB is 1. Otherwise the upper bits keep their value and the new LSB is 0.
  - cnt increments each step. After step 32 (cnt reaches 32) → END.
  - On the transition into END, sign correction is applied and the result is registered.
- Sign correction (signed mode only):
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder is negated when the dividend is negative.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. There is no trap; it wraps.
- BYZERO → END next cycle with `result_o`=0.
- END:
  - `ready_o`=1 and `result_o` is held stable.
  - Stays in END while `start_i`=1.
  - `start_i`=0 → FREE, with `ready_o` and `result_o` cleared.
- `annul_i`=1 in ON, BYZERO or END → FREE next edge, with `ready_o`=0 and `result_o`=0. No result is ever presented for an annulled operation.
- `annul_i` and `start_i` both high in FREE: stay in FREE.

## Timing
- Reset (asynchronous, `rst`=0):
  - State = FREE, cnt = 0, working register = 0.
  - `ready_o`=0 and `result_o`=0, immediately and independent of `clk`.
  - Reset asserted mid-operation discards the operation. After release the block is idle and needs a fresh start.
- Nonzero divisor, start sampled at edge E0:
  - ON iterates on edges E1..E32.
  - END is entered at E32 with the corrected result registered.
  - `ready_o`=1 from the cycle after E32, i.e. 33 cycles after the start edge.
- Zero divisor: BYZERO at E0, END at E1, `ready_o`=1 two cycles after the start edge.
- Outputs are registered; there is no combinational path from inputs to `ready_o` or `result_o`.
- Back-to-back operations: `start_i` must drop for at least one cycle (END→FREE) before the next start is accepted.
- Operand inputs may change freely after the start edge; the captured copies are used.

## Test plan
- Unsigned 100 / 7 → `result_o`=0x00000002_0000000E, `ready_o` rises 33 cycles after the start edge and holds while `start_i`=1.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Unsigned mode with the same operands → quotient 0x7FFFFFFC, remainder 0x00000001.
- Divisor 0 (any dividend, either mode) → `ready_o` two cycles after start, `result_o`=0. Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
- `annul_i` pulsed at cnt=10 → FREE next edge, `ready_o` never asserts. A following new start of 9/3 returns 0x00000000_00000003.
- `rst` low at cnt=20 → outputs 0 immediately. After release with `start_i` low the block stays idle. A new start then completes in 33 cycles.
- Drop `start_i` in END → `ready_o`/`result_o` cleared next cycle. A re-start in the following cycle is accepted normally.
